// File: rtl/regfile_pkg.sv
// Shared definitions for the register file with integrated scoreboard.
// Contents:
//   XLEN_DEFAULT, NREGS_DEFAULT : default data width and register count
//   REG_ZERO                    : the hard-wired zero register address
//   wb_port_t                   : write-back port bundle at the default sizes
package regfile_pkg;

    localparam int unsigned XLEN_DEFAULT  = 32;
    localparam int unsigned NREGS_DEFAULT = 32;
    localparam int unsigned REG_ZERO      = 0;

    typedef struct packed {
        logic                             valid;
        logic [$clog2(NREGS_DEFAULT)-1:0] address;
        logic [XLEN_DEFAULT-1:0]          data;
    } wb_port_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Scoreboard for regfile_sb: one pending bit per architectural register.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   rs_address            : NREAD packed read addresses
//   rs_busy               : per read port, pending and not being written back now
//   issue_valid, issue_rd : request to mark issue_rd pending
//   issue_ready           : issue would be accepted this cycle
//   wbN_valid, wbN_address: write-back strobes that clear pending bits
//   flush                 : clears every pending bit at the next edge
//   busy_any              : OR of all pending bits
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NREAD = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREAD*AW-1:0] rs_address,
    output logic [NREAD-1:0]  rs_busy,
    input  logic              issue_valid,
    input  logic [AW-1:0]     issue_rd,
    output logic              issue_ready,
    input  logic              wb0_valid,
    input  logic [AW-1:0]     wb0_address,
    input  logic              wb1_valid,
    input  logic [AW-1:0]     wb1_address,
    input  logic              flush,
    output logic              busy_any
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             issue_wb_hit;
    logic             issue_accept;

    assign issue_wb_hit = (wb0_valid && (wb0_address == issue_rd)) ||
                          (wb1_valid && (wb1_address == issue_rd));
    assign issue_ready  = (issue_rd == AW'(REG_ZERO)) || !busy_q[issue_rd] || issue_wb_hit;
    assign issue_accept = issue_valid && issue_ready;
    assign busy_any     = |busy_q;

    // Priority per register: flush, then issue (new producer), then write-back.
    always_comb begin
        busy_d = busy_q;
        busy_d[REG_ZERO] = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (issue_accept && (issue_rd == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((wb0_valid && (wb0_address == AW'(r))) ||
                         (wb1_valid && (wb1_address == AW'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_rs_busy
        logic [AW-1:0] addr;
        logic          wb_hit;
        assign addr       = rs_address[i*AW +: AW];
        assign wb_hit     = (wb0_valid && (wb0_address == addr)) ||
                            (wb1_valid && (wb1_address == addr));
        // A write-back landing this cycle already satisfies the reader.
        assign rs_busy[i] = busy_q[addr] && !wb_hit;
    end

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with write-back bypass and an integrated scoreboard.
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   rs_address, rs_data   : NREAD packed combinational read ports (bypassed)
//   rs_busy               : per read port, operand still pending
//   issue_valid, issue_rd : mark a destination pending; issue_ready = accepted
//   wbN_valid/address/data: two write-back ports, wb1 wins on a collision
//   flush                 : clears all pending bits, data is kept
//   busy_any              : any register pending
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int unsigned XLEN  = XLEN_DEFAULT,
    parameter int unsigned NREGS = NREGS_DEFAULT,
    parameter int unsigned NREAD = 2,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREAD*AW-1:0]   rs_address,
    output logic [NREAD*XLEN-1:0] rs_data,
    output logic [NREAD-1:0]      rs_busy,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic                  issue_ready,
    input  logic                  wb0_valid,
    input  logic [AW-1:0]         wb0_address,
    input  logic [XLEN-1:0]       wb0_data,
    input  logic                  wb1_valid,
    input  logic [AW-1:0]         wb1_address,
    input  logic [XLEN-1:0]       wb1_data,
    input  logic                  flush,
    output logic                  busy_any
);

    logic [XLEN-1:0] regs [NREGS];

    // wb1 is applied last so it wins a same-address collision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else begin
            if (wb0_valid && (wb0_address != AW'(REG_ZERO))) begin
                regs[wb0_address] <= wb0_data;
            end
            if (wb1_valid && (wb1_address != AW'(REG_ZERO))) begin
                regs[wb1_address] <= wb1_data;
            end
        end
    end

    for (genvar i = 0; i < NREAD; i++) begin : g_read
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] rd_val;
        assign addr = rs_address[i*AW +: AW];
        always_comb begin
            if (addr == AW'(REG_ZERO)) begin
                rd_val = '0;
            end else if (wb1_valid && (wb1_address == addr)) begin
                rd_val = wb1_data;
            end else if (wb0_valid && (wb0_address == addr)) begin
                rd_val = wb0_data;
            end else begin
                rd_val = regs[addr];
            end
        end
        assign rs_data[i*XLEN +: XLEN] = rd_val;
    end

    regfile_scoreboard #(
        .NREGS(NREGS),
        .NREAD(NREAD),
        .AW   (AW)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .rs_address (rs_address),
        .rs_busy    (rs_busy),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .wb0_valid  (wb0_valid),
        .wb0_address(wb0_address),
        .wb1_valid  (wb1_valid),
        .wb1_address(wb1_address),
        .flush      (flush),
        .busy_any   (busy_any)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (NREAD=3, XLEN=64, NREGS=16).
module tb_regfile_sb;

    localparam int unsigned XLEN  = 64;
    localparam int unsigned NREGS = 16;
    localparam int unsigned NREAD = 3;
    localparam int unsigned AW    = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREAD*AW-1:0]   rs_address;
    logic [NREAD*XLEN-1:0] rs_data;
    logic [NREAD-1:0]      rs_busy;
    logic                  issue_valid;
    logic [AW-1:0]         issue_rd;
    logic                  issue_ready;
    logic                  wb0_valid;
    logic [AW-1:0]         wb0_address;
    logic [XLEN-1:0]       wb0_data;
    logic                  wb1_valid;
    logic [AW-1:0]         wb1_address;
    logic [XLEN-1:0]       wb1_data;
    logic                  flush;
    logic                  busy_any;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_sb #(
        .XLEN (XLEN),
        .NREGS(NREGS),
        .NREAD(NREAD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rs_address (rs_address),
        .rs_data    (rs_data),
        .rs_busy    (rs_busy),
        .issue_valid(issue_valid),
        .issue_rd   (issue_rd),
        .issue_ready(issue_ready),
        .wb0_valid  (wb0_valid),
        .wb0_address(wb0_address),
        .wb0_data   (wb0_data),
        .wb1_valid  (wb1_valid),
        .wb1_address(wb1_address),
        .wb1_data   (wb1_data),
        .flush      (flush),
        .busy_any   (busy_any)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_rd    = '0;
        wb0_valid   = 1'b0;
        wb0_address = '0;
        wb0_data    = '0;
        wb1_valid   = 1'b0;
        wb1_address = '0;
        wb1_data    = '0;
        flush       = 1'b0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rs_address[p*AW +: AW] = a;
    endtask

    function automatic logic [63:0] rd(input int p);
        return rs_data[p*XLEN +: XLEN];
    endfunction

    // Inputs change 1ns after the rising edge; checks land between edges.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        rs_address = '0;
        idle();
        // In reset: bypass still works, scoreboard is clear.
        wb1_valid   = 1'b1;
        wb1_address = 4'd5;
        wb1_data    = 64'h77;
        set_rd(0, 4'd5);
        #2;
        check("rst_bypass", rd(0), 64'h77);
        check("rst_busy_any", {63'd0, busy_any}, 64'd0);
        check("rst_issue_ready", {63'd0, issue_ready}, 64'd1);
        check("rst_rs_busy", {61'd0, rs_busy}, 64'd0);
        tick();
        reset = 1'b0;
        idle();
        #1;

        // Every address reads 0 and not busy, including x5 written during reset.
        for (int a = 0; a < NREGS; a++) begin
            for (int p = 0; p < NREAD; p++) set_rd(p, AW'(a));
            #1;
            check("init_data", rd(a % NREAD), 64'd0);
            check("init_busy", {61'd0, rs_busy}, 64'd0);
        end

        // Write to x0 is ignored, both bypass and array.
        set_rd(0, 4'd0);
        wb0_valid = 1'b1; wb0_address = 4'd0; wb0_data = 64'hDEADBEEF;
        #1;
        check("x0_same", rd(0), 64'd0);
        tick();
        idle();
        #1;
        check("x0_next", rd(0), 64'd0);

        // Collision on x5: wb1 wins both in bypass and array.
        set_rd(0, 4'd5);
        wb0_valid = 1'b1; wb0_address = 4'd5; wb0_data = 64'h11;
        wb1_valid = 1'b1; wb1_address = 4'd5; wb1_data = 64'h22;
        #1;
        check("x5_bypass", rd(0), 64'h22);
        tick();
        idle();
        #1;
        check("x5_array", rd(0), 64'h22);

        // Independent bypasses on separate ports.
        set_rd(0, 4'd12); set_rd(1, 4'd13); set_rd(2, 4'd5);
        wb0_valid = 1'b1; wb0_address = 4'd12; wb0_data = 64'hC0;
        wb1_valid = 1'b1; wb1_address = 4'd13; wb1_data = 64'hD0;
        #1;
        check("byp_wb0", rd(0), 64'hC0);
        check("byp_wb1", rd(1), 64'hD0);
        check("byp_none", rd(2), 64'h22);
        tick();
        idle();

        // Issue x7, then check pending, then release via wb1 with a new issue.
        issue_valid = 1'b1; issue_rd = 4'd7;
        #1;
        check("x7_issue_ready", {63'd0, issue_ready}, 64'd1);
        tick();
        idle();
        set_rd(1, 4'd7);
        issue_rd = 4'd7;
        #1;
        check("x7_rs_busy", {63'd0, rs_busy[1]}, 64'd1);
        check("x7_ready_blocked", {63'd0, issue_ready}, 64'd0);
        check("x7_busy_any", {63'd0, busy_any}, 64'd1);
        wb1_valid = 1'b1; wb1_address = 4'd7; wb1_data = 64'h55;
        issue_valid = 1'b1;
        #1;
        check("x7_wb_busy", {63'd0, rs_busy[1]}, 64'd0);
        check("x7_wb_data", rd(1), 64'h55);
        check("x7_wb_ready", {63'd0, issue_ready}, 64'd1);
        tick();
        idle();
        #1;
        // Re-issue in the write-back cycle wins: still pending.
        check("x7_reissue_busy", {63'd0, rs_busy[1]}, 64'd1);
        check("x7_reissue_data", rd(1), 64'h55);
        wb0_valid = 1'b1; wb0_address = 4'd7; wb0_data = 64'h66;
        tick();
        idle();
        #1;
        check("x7_clear_busy", {63'd0, rs_busy[1]}, 64'd0);
        check("x7_clear_data", rd(1), 64'h66);
        check("x7_clear_any", {63'd0, busy_any}, 64'd0);

        // Issue and write-back to x9 in the same cycle.
        issue_valid = 1'b1; issue_rd = 4'd9;
        wb0_valid = 1'b1; wb0_address = 4'd9; wb0_data = 64'h99;
        tick();
        idle();
        set_rd(2, 4'd9);
        #1;
        check("x9_busy", {63'd0, rs_busy[2]}, 64'd1);
        check("x9_data", rd(2), 64'h99);

        // Issue x3, x4, x6, then flush with issue x8.
        issue_valid = 1'b1; issue_rd = 4'd3;
        tick();
        issue_rd = 4'd4;
        tick();
        issue_rd = 4'd6;
        tick();
        issue_rd = 4'd8;
        flush = 1'b1;
        set_rd(0, 4'd3); set_rd(1, 4'd8);
        #1;
        check("flush_cycle_old_busy", {63'd0, rs_busy[0]}, 64'd1);
        check("flush_x8_ready", {63'd0, issue_ready}, 64'd1);
        tick();
        idle();
        #1;
        check("flush_busy_any", {63'd0, busy_any}, 64'd0);
        check("flush_x8_busy", {63'd0, rs_busy[1]}, 64'd0);
        check("flush_data_kept", rd(2), 64'h99);

        // Make x10 pending with data 0xA, then reset between edges.
        issue_valid = 1'b1; issue_rd = 4'd10;
        wb0_valid = 1'b1; wb0_address = 4'd10; wb0_data = 64'hA;
        tick();
        idle();
        set_rd(2, 4'd10); set_rd(0, 4'd5);
        issue_rd = 4'd10;
        #1;
        check("x10_busy", {63'd0, rs_busy[2]}, 64'd1);
        check("x10_data", rd(2), 64'hA);
        check("x10_any", {63'd0, busy_any}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        check("arst_busy_any", {63'd0, busy_any}, 64'd0);
        check("arst_x10_data", rd(2), 64'd0);
        check("arst_x10_busy", {63'd0, rs_busy[2]}, 64'd0);
        check("arst_x5_data", rd(0), 64'd0);
        check("arst_ready", {63'd0, issue_ready}, 64'd1);
        tick();
        reset = 1'b0;
        #1;
        check("post_rst_x10", rd(2), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
